// File: rtl/vedic_seq_mul8_if.sv
// Operand/handshake bundle for the sequential Vedic multiplier.
// The master supplies operands and start; the slave returns busy, done and the product.
interface vedic_seq_mul8_if #(
  parameter int W = 8
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] p;

  modport master (output start, a, b, input busy, done, p);
  modport slave  (input start, a, b, output busy, done, p);
endinterface

// File: rtl/vedic_seq_mul8.sv
// Sequential WxW unsigned multiplier: one (W/2)x(W/2) Urdhva-Tiryagbhyam unit
// reused over four steps, with the shifted partial products summed into a 2W-bit result.
//
//   state  | meaning
//   S_IDLE | waiting for start
//   S_MUL  | four accumulate steps, step_q = 0..3
//   S_DONE | one-cycle result pulse; a start here is accepted immediately
module vedic_seq_mul8 #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  vedic_seq_mul8_if.slave bus
);
  localparam int H  = W / 2;
  localparam int PW = 2 * H;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   aq_q, aq_d, bq_q, bq_d;
  logic [2*W-1:0] acc_q, acc_d, p_q, p_d;
  logic [1:0]     step_q, step_d;

  logic [H-1:0]   pa, pb;
  logic [PW-1:0]  pp;
  logic [2*W-1:0] pp_ext, term;

  // step bit 1 selects the upper half of a, step bit 0 the upper half of b
  assign pa = step_q[1] ? aq_q[W-1:H] : aq_q[H-1:0];
  assign pb = step_q[0] ? bq_q[W-1:H] : bq_q[H-1:0];

  // Vertical-and-crosswise columns: column c collects every pa[i]&pb[c-i].
  logic [PW-1:0] part [2*H];
  assign part[0] = '0;

  for (genvar c = 0; c < 2*H-1; c++) begin : g_col
    logic [H-1:0]  vert;
    logic [PW-1:0] col;
    for (genvar i = 0; i < H; i++) begin : g_term
      if ((c - i >= 0) && (c - i < H)) begin : g_on
        assign vert[i] = pa[i] & pb[c-i];
      end else begin : g_off
        assign vert[i] = 1'b0;
      end
    end
    assign col = PW'($countones(vert));
    assign part[c+1] = part[c] + (col << c);
  end

  assign pp     = part[2*H-1];
  assign pp_ext = {{(2*W-PW){1'b0}}, pp};

  always_comb begin
    term = pp_ext;
    case (step_q)
      2'd0:    term = pp_ext;
      2'd1,
      2'd2:    term = pp_ext << H;
      default: term = pp_ext << W;
    endcase
  end

  always_comb begin
    state_d = state_q;
    aq_d    = aq_q;
    bq_d    = bq_q;
    acc_d   = acc_q;
    p_d     = p_q;
    step_d  = step_q;
    case (state_q)
      S_MUL: begin
        if (step_q == 2'd3) begin
          p_d     = acc_q + term;
          state_d = S_DONE;
        end else begin
          acc_d  = acc_q + term;
          step_d = step_q + 2'd1;
        end
      end
      default: begin
        if (bus.start) begin
          aq_d    = bus.a;
          bq_d    = bus.b;
          acc_d   = '0;
          step_d  = 2'd0;
          state_d = S_MUL;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      aq_q    <= '0;
      bq_q    <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      aq_q    <= aq_d;
      bq_q    <= bq_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      step_q  <= step_d;
    end
  end

  assign bus.busy = (state_q == S_MUL);
  assign bus.done = (state_q == S_DONE);
  assign bus.p    = p_q;
endmodule

// File: tb/tb_vedic_seq_mul8.sv
// Directed and randomized checks for the sequential Vedic multiplier.
module tb_vedic_seq_mul8;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vedic_seq_mul8_if #(.W(8)) bus ();
  vedic_seq_mul8 #(.W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one start and wait (bounded) for the done pulse
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] p_o, output int lat);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    tick();
    bus.start = 1'b0;
    lat       = 0;
    p_o       = 16'hxxxx;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i;
        p_o = bus.p;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
      checks++; if (bus.p !== 16'h0000) begin errors++; $display("FAIL reset_p: got %h want 0000", bus.p); end
    end
    rst = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL post_reset_done: got %b want 0", bus.done); end
    checks++; if (bus.p !== 16'h0000) begin errors++; $display("FAIL post_reset_p: got %h want 0000", bus.p); end
  endtask

  task automatic test_basic();
    bus.start = 1'b1;
    bus.a = 8'h0D;
    bus.b = 8'hB7;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_k: got %b want 1", bus.busy); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0)
        begin errors++; $display("FAIL basic_mid%0d: got busy=%b done=%b want busy=1 done=0", i, bus.busy, bus.done); end
    end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL basic_done: got busy=%b done=%b want busy=0 done=1", bus.busy, bus.done); end
    checks++; if (bus.p !== 16'h094B) begin errors++; $display("FAIL basic_p: got %h want 094B", bus.p); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.done !== 1'b0 || bus.p !== 16'h094B)
        begin errors++; $display("FAIL basic_hold%0d: got done=%b p=%h want done=0 p=094B", i, bus.done, bus.p); end
    end
  endtask

  task automatic test_extremes();
    logic [7:0]  va [3] = '{8'hFF, 8'h00, 8'h80};
    logic [7:0]  vb [3] = '{8'hFF, 8'hA5, 8'h02};
    logic [15:0] vp [3] = '{16'hFE01, 16'h0000, 16'h0100};
    logic [15:0] got;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], got, lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL extreme%0d_latency: got %0d want 4", i, lat); end
      checks++; if (got !== vp[i]) begin errors++; $display("FAIL extreme%0d_p: got %h want %h", i, got, vp[i]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int          t1 = 0, t2 = 0;
    logic [15:0] p1 = '0, p2 = '0;
    bus.start = 1'b1;
    bus.a = 8'h12;
    bus.b = 8'h34;
    tick();
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++; if (bus.busy === 1'b1 && bus.done === 1'b1)
        begin errors++; $display("FAIL b2b_overlap: got busy=1 done=1 want not both"); end
      if (bus.done === 1'b1) begin
        if (t1 == 0) begin
          t1 = i; p1 = bus.p;
        end else begin
          t2 = i; p2 = bus.p;
          break;
        end
      end
    end
    bus.start = 1'b0;
    tick();
    checks++; if (t1 != 4) begin errors++; $display("FAIL b2b_first_time: got %0d want 4", t1); end
    checks++; if (p1 !== 16'h03A8) begin errors++; $display("FAIL b2b_first_p: got %h want 03A8", p1); end
    checks++; if (t2 != 9) begin errors++; $display("FAIL b2b_second_time: got %0d want 9", t2); end
    checks++; if (p2 !== 16'hFE01) begin errors++; $display("FAIL b2b_second_p: got %h want FE01", p2); end
    checks++; if (t2 - t1 != 5) begin errors++; $display("FAIL b2b_spacing: got %0d want 5", t2 - t1); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    int          lat;
    logic        seen = 1'b0;
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.p !== 16'h0000) begin errors++; $display("FAIL mid_rst_p: got %h want 0000", bus.p); end
    if (bus.done === 1'b1) seen = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_rst_no_done: got done pulse want none"); end
    do_op(8'h03, 8'h05, got, lat);
    checks++; if (lat != 4) begin errors++; $display("FAIL mid_rst_recover_latency: got %0d want 4", lat); end
    checks++; if (got !== 16'h000F) begin errors++; $display("FAIL mid_rst_recover_p: got %h want 000F", got); end
  endtask

  task automatic test_random();
    logic [7:0]  a, b;
    logic [15:0] exp, got;
    int          gap, lat;
    for (int n = 0; n < 1000; n++) begin
      gap = $urandom_range(0, 3);
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      exp = 16'(a) * 16'(b);
      bus.start = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0)
          begin errors++; $display("FAIL rand%0d_gap: got busy=%b done=%b want 0 0", n, bus.busy, bus.done); end
      end
      bus.start = 1'b1;
      bus.a = a;
      bus.b = b;
      tick();
      bus.start = 1'b0;
      bus.a = ~a;
      bus.b = ~b;
      lat = 0;
      got = 16'hxxxx;
      for (int i = 1; i <= 8; i++) begin
        tick();
        checks++; if (bus.busy === 1'b1 && bus.done === 1'b1)
          begin errors++; $display("FAIL rand%0d_overlap: got busy=1 done=1 want not both", n); end
        if (bus.done === 1'b1) begin
          lat = i;
          got = bus.p;
          break;
        end
      end
      checks++; if (lat != 4) begin errors++; $display("FAIL rand%0d_latency: got %0d want 4", n, lat); end
      checks++; if (got !== exp) begin errors++; $display("FAIL rand%0d_p: a=%h b=%h got %h want %h", n, a, b, got, exp); end
    end
    bus.start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vedic_seq_mul8.md
# vedic_seq_mul8

Multi-cycle W×W unsigned multiplier controller. It time-shares a single (W/2)×(W/2) Urdhva-Tiryagbhyam partial-product unit across four cycles and accumulates the shifted partial products into a 2W-bit result. The block sits between operand-producing logic and the gate-level Vedic multiplier cores. It trades throughput for area: one small product unit replaces the four of a fully parallel Vedic array. A start/busy/done handshake sequences it.

## Interface
- W, default 8: operand width; must be even; H = W/2 is the product-unit width.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request; sampled on the rising edge of clk.
- a  in  W  multiplicand (unsigned); captured on an accepted start.
- b  in  W  multiplier (unsigned); captured on an accepted start.
- busy  out  1  high while the four accumulate steps are in progress.
- done  out  1  one-cycle pulse; p is valid and new during this cycle.
- p  out  2W  product; holds its value until the next completion.

## Operation
- Exactly one H×H combinational product unit is instantiated; the controller muxes operand halves into it.
- FSM states:
  - IDLE: busy=0, done=0.
  - MUL: busy=1; a 2-bit step counter runs 0..3.
  - DONE: busy=0, done=1.
- Accept rule: start is accepted only in IDLE or DONE. Start in MUL is ignored and has no side effects.
- On accept:
  - aq←a, bq←b, acc←0, step←0, state→MUL.
- MUL step schedule (acc += pp << shift, acc is 2W bits):
  - step0: aq[H-1:0]·bq[H-1:0], shift 0.
  - step1: aq[H-1:0]·bq[W-1:H], shift H.
  - step2: aq[W-1:H]·bq[H-1:0], shift H.
  - step3: aq[W-1:H]·bq[W-1:H], shift W.
- On the step3 edge:
  - p ← final sum (acc + step3 term). p is written directly, not via acc.
  - state→DONE.
- DONE exit: without start, DONE→IDLE. With start, the new accept happens and the state goes straight to MUL.
- Arithmetic: acc and p are 2W bits, unsigned. The maximum (2^W−1)² fits, so no overflow or truncation occurs.
- Operand changes on a/b after acceptance have no effect; aq and bq are frozen until the next accept.
- Reset (any state, including mid-MUL):
  - state→IDLE.
  - busy=0, done=0, p=0, acc=0, aq=0, bq=0, step=0.
  - An interrupted operation never produces done.

## Timing
- Reset values: busy=0, done=0, p=0 in the cycle after the rst edge. rst has priority over start.
- Start accepted at edge k:
  - busy=1 from k to k+4.
  - Steps 0..3 execute on edges k+1..k+4.
  - done=1 and p valid from k+4 to k+5.
- Latency: done is seen high 4 cycles after the accepting edge.
- Throughput:
  - start held high: one result every 5 cycles.
  - done asserted and start accepted at the same edge.
- done is registered, never combinational from start; it is exactly 1 cycle wide.
- busy and done are never high together.

## Test plan
- Reset: hold rst 2 cycles with start=1, a=0xFF, b=0xFF → busy=0, done=0, p=0x0000 throughout and 1 cycle after release.
- Basic: a=0x0D, b=0xB7, start pulse at edge k → busy high k..k+4; done pulse k+4..k+5; p=0x094B; p holds 0x094B for 10 idle cycles.
- Extremes:
  - a=0xFF, b=0xFF → p=0xFE01.
  - a=0x00, b=0xA5 → p=0x0000 with done still pulsing.
  - a=0x80, b=0x02 → p=0x0100.
- Ignore-while-busy: accept a=0x12, b=0x34, then drive start=1 with a=0xFF, b=0xFF during MUL → p=0x03A8, followed by a second result 0xFE01 accepted at the done edge. Measure 5-cycle spacing between done pulses.
- Reset mid-operation: accept a=0xFF, b=0xFF, assert rst at step2 → next cycle busy=0, p=0, no done pulse. Then accept a=0x03, b=0x05 → p=0x000F after 4 cycles.
- Random: 1000 operations with random operands and random start gaps (0–3 cycles) → every p equals a·b, exactly one done per accepted start, busy/done never overlap.
